// File: rtl/hold_arbiter.sv
// rtl/hold_arbiter.sv - 386SX HOLD/HOLDA bus-master arbiter with round-robin grant
// Raises HOLD for any request, grants one master once HOLDA is seen, hands off without dropping HOLD.
module hold_arbiter #(
  parameter int NREQ          = 2,
  parameter int MAX_TENURE    = 64,
  parameter int HOLDA_TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] preempt,
  output logic            hold,
  input  logic            holda,
  output logic            busy,
  output logic            err,
  output logic [2:0]      owner
);
  localparam int TW = $clog2(MAX_TENURE + 1);
  localparam int CW = $clog2(HOLDA_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HREQ, GRANT, HANDOFF, RELEASE} state_t;

  state_t          state_q, state_d;
  logic            holda_m_q, holda_s_q;
  logic            hold_q, hold_d;
  logic            err_q, err_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] preempt_q, preempt_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      rr_q, rr_d;
  logic [TW-1:0]   tenure_q, tenure_d, tenure_inc;
  logic [CW-1:0]   tmo_q, tmo_d;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   own_mask, win_oh, others;
  logic [2:0]        win_idx, rr_next;
  logic              win_found, own_req, tmo_hit, load_win;

  // Rotate requests so bit 0 is the round-robin pointer; first set bit wins.
  assign req_dbl = {req, req} >> rr_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && req_dbl[k]) begin
        win_found = 1'b1;
        win_idx   = 3'((int'(rr_q) + k) % NREQ);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      own_mask[i] = (owner_q == 3'(i));
      win_oh[i]   = (win_idx == 3'(i));
    end
    rr_next = 3'((int'(win_idx) + 1) % NREQ);
  end

  assign others  = req & ~own_mask;
  assign own_req = |(req & own_mask);
  assign tmo_hit = (tmo_q == CW'(HOLDA_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      holda_m_q <= 1'b0;
      holda_s_q <= 1'b0;
      hold_q    <= 1'b0;
      err_q     <= 1'b0;
      grant_q   <= '0;
      preempt_q <= '0;
      owner_q   <= '0;
      rr_q      <= '0;
      tenure_q  <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      holda_m_q <= holda;
      holda_s_q <= holda_m_q;
      hold_q    <= hold_d;
      err_q     <= err_d;
      grant_q   <= grant_d;
      preempt_q <= preempt_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      tenure_q  <= tenure_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = HREQ;
      HREQ: begin
        if (!(|req))         state_d = RELEASE;
        else if (holda_s_q)  state_d = GRANT;
        else if (tmo_hit)    state_d = RELEASE;
      end
      GRANT: begin
        if (!holda_s_q)      state_d = RELEASE;
        else if (!own_req)   state_d = (|others) ? HANDOFF : RELEASE;
      end
      HANDOFF: begin
        if (holda_s_q && win_found) state_d = GRANT;
        else                        state_d = RELEASE;
      end
      RELEASE: if (!holda_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_d     = hold_q;
    err_d      = err_q;
    grant_d    = grant_q;
    preempt_d  = preempt_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    tenure_d   = tenure_q;
    tmo_d      = tmo_q;
    load_win   = 1'b0;
    tenure_inc = (tenure_q == TW'(MAX_TENURE)) ? tenure_q : tenure_q + TW'(1);
    case (state_q)
      IDLE: begin
        hold_d = |req;
        tmo_d  = '0;
      end
      HREQ: begin
        hold_d = 1'b1;
        tmo_d  = tmo_q + CW'(1);
        if (|req && holda_s_q)   load_win = 1'b1;
        else if (|req && tmo_hit) err_d   = 1'b1;
      end
      GRANT: begin
        if (!holda_s_q) begin
          err_d     = 1'b1;
          grant_d   = '0;
          preempt_d = '0;
        end else if (!own_req) begin
          grant_d   = '0;
          preempt_d = '0;
        end else begin
          tenure_d = tenure_inc;
          // Preempt is only a request to yield; grant stays until req drops.
          if (tenure_inc == TW'(MAX_TENURE) && |others) preempt_d = own_mask;
        end
      end
      HANDOFF: begin
        if (!holda_s_q)     err_d    = 1'b1;
        else if (win_found) load_win = 1'b1;
      end
      RELEASE: hold_d = 1'b0;
      default: hold_d = 1'b0;
    endcase
    if (load_win) begin
      grant_d   = win_oh;
      preempt_d = '0;
      owner_d   = win_idx;
      rr_d      = rr_next;
      tenure_d  = '0;
    end
  end

  assign grant   = grant_q;
  assign preempt = preempt_q;
  assign hold    = hold_q;
  assign err     = err_q;
  assign owner   = owner_q;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_hold_arbiter.sv
// tb/tb_hold_arbiter.sv - directed and randomized checks of hold_arbiter
// Random phase compares against a round-robin / tenure model built from the bus rules.
module tb_hold_arbiter;
  localparam int NREQ = 2;
  localparam int MAXT = 8;
  localparam int TMO  = 15;

  logic            clk, reset_n, holda, hold, busy, err;
  logic [NREQ-1:0] req, grant, preempt;
  logic [2:0]      owner;

  int n_checks, n_errors;
  bit cpu_auto;
  logic [1:0] hold_hist;

  // random-phase model state
  logic [NREQ-1:0] ra, prev_grant;
  int m_rr, n_ten, w;
  bit pexp, gap_pending, gap_ho;
  logic [1:0] rr_exp [3];

  hold_arbiter #(.NREQ(NREQ), .MAX_TENURE(MAXT), .HOLDA_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .grant(grant), .preempt(preempt),
    .hold(hold), .holda(holda), .busy(busy), .err(err), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample point is the falling edge; the CPU answers HOLD after two cycles.
  task automatic cyc();
    @(negedge clk);
    if (cpu_auto) begin
      hold_hist = {hold_hist[0], hold};
      holda     = hold_hist[1];
    end
  endtask

  task automatic reset_dut(input bit auto_cpu);
    req = '0; holda = 1'b0; hold_hist = '0; cpu_auto = auto_cpu;
    reset_n = 1'b0;
    cyc(); cyc();
    check("rst_hold", hold, 0);
    check("rst_grant", grant, 0);
    check("rst_preempt", preempt, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_owner", owner, 0);
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic wait_grant(input string tag);
    int k = 0;
    while (grant == '0 && k < 40) begin cyc(); k++; end
    check(tag, grant != '0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 40) begin cyc(); k++; end
    check(tag, busy, 0);
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int start);
    for (int k = 0; k < NREQ; k++)
      if (r[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  initial begin
    n_checks = 0; n_errors = 0;
    reset_n = 1'b0; req = '0; holda = 1'b0; cpu_auto = 1'b0; hold_hist = '0;

    // basic grant latency and release
    reset_dut(0);
    req = 2'b01; cyc();
    check("t1_hold_rise", hold, 1);
    check("t1_busy", busy, 1);
    cyc(); holda = 1'b1;
    cyc(); check("t1_lat1", grant, 0);
    cyc(); check("t1_lat2", grant, 0);
    cyc(); check("t1_grant", grant, 2'b01);
    check("t1_owner", owner, 0);
    req = 2'b00; cyc();
    check("t1_grant_off", grant, 0);
    check("t1_hold_still", hold, 1);
    cyc(); check("t1_hold_off", hold, 0);
    holda = 1'b0;
    wait_idle("t1_idle");

    // same-HOLD handoff
    reset_dut(1);
    req = 2'b11; wait_grant("t2_wait");
    check("t2_grant0", grant, 2'b01);
    check("t2_owner0", owner, 0);
    req = 2'b10; cyc();
    check("t2_gap_grant", grant, 0);
    check("t2_gap_hold", hold, 1);
    cyc();
    check("t2_grant1", grant, 2'b10);
    check("t2_owner1", owner, 1);
    check("t2_hold_kept", hold, 1);
    req = 2'b00; cyc(); wait_idle("t2_idle");

    // round-robin across separate HOLD tenures
    rr_exp = '{2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 3; i++) begin
      req = 2'b11; wait_grant("t3_wait");
      check("t3_rr", grant, rr_exp[i]);
      req = 2'b00; cyc(); wait_idle("t3_idle");
    end

    // tenure limit and preempt
    reset_dut(1);
    req = 2'b01; wait_grant("t4_wait");
    for (int n = 1; n <= MAXT; n++) begin
      cyc();
      if (n == 3) req = 2'b11;
      if (n == MAXT - 1) check("t4_pre_early", preempt, 0);
    end
    check("t4_preempt", preempt, 2'b01);
    for (int n = 0; n < 5; n++) begin
      cyc();
      check("t4_keep_grant", grant, 2'b01);
    end
    check("t4_keep_pre", preempt, 2'b01);
    req = 2'b10; cyc();
    check("t4_pre_clr", preempt, 0);
    check("t4_gap", grant, 0);
    cyc(); check("t4_next", grant, 2'b10);
    req = 2'b00; cyc(); wait_idle("t4_idle");

    // HOLDA timeout, sticky error
    reset_dut(0);
    req = 2'b01; cyc();
    check("t5_hold", hold, 1);
    repeat (TMO - 1) cyc();
    check("t5_err_early", err, 0);
    cyc();
    check("t5_err", err, 1);
    req = 2'b00; cyc();
    check("t5_hold_off", hold, 0);
    wait_idle("t5_idle");
    cpu_auto = 1'b1; hold_hist = '0;
    req = 2'b01; wait_grant("t5_wait");
    check("t5_grant_ok", grant, 2'b01);
    check("t5_err_sticky", err, 1);
    req = 2'b00; cyc(); wait_idle("t5_idle2");
    check("t5_err_sticky2", err, 1);

    // HOLDA dropped during grant, then async reset mid-grant
    reset_dut(0);
    req = 2'b01; cyc(); holda = 1'b1;
    wait_grant("t6_wait");
    holda = 1'b0;
    cyc(); cyc(); cyc();
    check("t6_grant_off", grant, 0);
    check("t6_err", err, 1);
    req = 2'b00; cyc();
    check("t6_hold_off", hold, 0);
    wait_idle("t6_idle");
    req = 2'b01; cyc(); holda = 1'b1;
    wait_grant("t6_wait2");
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_hold", hold, 0);
    check("t6_async_grant", grant, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_err", err, 0);
    reset_dut(1);

    // randomized traffic against the model
    prev_grant = '0; m_rr = 0; n_ten = 0; pexp = 0; gap_pending = 0; gap_ho = 0;
    for (int c = 0; c < 4000; c++) begin
      cyc();
      ra = req;
      check("r_onehot", $countones(grant) <= 1, 1);
      if (gap_pending) begin
        if (gap_ho) check("r_handoff", grant != '0, 1);
        else        check("r_release_hold", hold, 0);
        gap_pending = 0;
      end
      if (grant != '0 && prev_grant == '0) begin
        w = rr_pick(ra, m_rr);
        check("r_rr_grant", grant, (w < 0) ? 0 : (1 << w));
        check("r_owner", owner, w);
        if (w >= 0) m_rr = (w + 1) % NREQ;
        n_ten = 0; pexp = 0;
      end
      if (grant != '0) begin
        if (grant == prev_grant) begin
          n_ten++;
          if (n_ten >= MAXT && (ra & ~grant) != '0) pexp = 1;
        end
        check("r_preempt", preempt, pexp ? grant : '0);
        check("r_grant_req", (grant & ra) != '0, 1);
        check("r_grant_hold", hold, 1);
      end else begin
        check("r_preempt0", preempt, 0);
      end
      if (prev_grant != '0 && grant == '0) begin
        gap_pending = 1;
        gap_ho = ((ra & ~prev_grant) != '0);
        check("r_gap_hold", hold, 1);
      end
      prev_grant = grant;
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) req[i] = 1'b1;
        end else if (grant[i]) begin
          if ($urandom_range(5) == 0 || (preempt[i] && $urandom_range(1) == 0)) req[i] = 1'b0;
        end
      end
    end
    check("r_no_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
